spi_slave_tx: RTL and testbench

SPI_SLAVE_TX -- requirements
Module: spi_slave_tx

---
 rtl/spi_slave_tx.sv | 176 +++++++++++++++++
 tb/tb_spi_slave_tx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_tx.sv
// SPI mode-1 slave transmitter: clk-domain oversampling of sck/cs,
// one-byte holding buffer, MSB-first shift-out with underrun/abort status.
module spi_slave_tx #(
  parameter logic [7:0] DEFAULT_BYTE = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       cs,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       miso,
  output logic       miso_oe,
  output logic       tx_done,
  output logic       underrun,
  output logic       frame_abort
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t      state_q, state_d;

  logic [2:0]  sck_sync_q, sck_sync_d;
  logic [2:0]  cs_sync_q, cs_sync_d;

  logic [7:0]  buf_q, buf_d;
  logic        full_q, full_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [2:0]  cnt_q, cnt_d;

  logic        tx_done_q, tx_done_d;
  logic        underrun_q, underrun_d;
  logic        frame_abort_q, frame_abort_d;

  logic        sck_rise;
  logic        sck_fall;
  logic        cs_rise;
  logic        cs_fall;
  logic        accept;
  logic        consume;

  // Two flops resynchronise the pins, the third holds the prior value
  // so edges are seen as a one-clk difference between stages 1 and 2.
  always_comb begin
    sck_sync_d = {sck_sync_q[1:0], sck};
    cs_sync_d  = {cs_sync_q[1:0], cs};
  end

  assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
  assign cs_rise  = cs_sync_q[1] & ~cs_sync_q[2];
  assign cs_fall  = ~cs_sync_q[1] & cs_sync_q[2];

  assign accept   = tx_valid & ~full_q;

  // Frame sequencing, shift register, bit counter and status pulses.
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    tx_done_d     = 1'b0;
    underrun_d    = 1'b0;
    frame_abort_d = 1'b0;
    consume       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (cs_rise) begin
          shreg_d = 8'h00;
          state_d = IDLE;
        end else if (sck_rise) begin
          consume = 1'b1;
          if (full_q) begin
            shreg_d = buf_q;
          end else begin
            shreg_d    = DEFAULT_BYTE;
            underrun_d = 1'b1;
          end
          cnt_d   = 3'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          frame_abort_d = 1'b1;
          shreg_d       = 8'h00;
          cnt_d         = 3'd0;
          state_d       = IDLE;
        end else if (sck_rise) begin
          shreg_d = {shreg_q[6:0], 1'b0};
        end else if (sck_fall) begin
          if (cnt_q == 3'd7) begin
            // Last bit has already been sampled by the master.
            tx_done_d = 1'b1;
            shreg_d   = 8'h00;
            cnt_d     = 3'd0;
            state_d   = ARMED;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Holding buffer: a load by the shifter empties it; a handshake fills it.
  // Only an underrun load can coincide with a handshake, and that byte is kept.
  always_comb begin
    buf_d  = buf_q;
    full_d = full_q;
    if (consume) begin
      full_d = 1'b0;
    end
    if (accept) begin
      buf_d  = tx_data;
      full_d = 1'b1;
    end
  end

  // Synchroniser registers; idle levels are sck low and cs high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync_q <= 3'b000;
      cs_sync_q  <= 3'b111;
    end else begin
      sck_sync_q <= sck_sync_d;
      cs_sync_q  <= cs_sync_d;
    end
  end

  // Datapath and control state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      buf_q         <= 8'h00;
      full_q        <= 1'b0;
      shreg_q       <= 8'h00;
      cnt_q         <= 3'd0;
      tx_done_q     <= 1'b0;
      underrun_q    <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      full_q        <= full_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      tx_done_q     <= tx_done_d;
      underrun_q    <= underrun_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  assign tx_ready    = ~full_q;
  assign miso_oe     = ~cs_sync_q[1];
  // Drive the bit the shifter is about to hold: the synchroniser costs
  // two clks, so this look-ahead keeps miso ahead of the master's falling
  // edge at the minimum sck phase width.
  assign miso        = miso_oe & shreg_d[7];
  assign tx_done     = tx_done_q;
  assign underrun    = underrun_q;
  assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_spi_slave_tx.sv
// Directed bench for spi_slave_tx: table of single-byte frames plus
// hand-written sequences for back-to-back, abort, overrun and reset.
module tb_spi_slave_tx;

  logic       clk;
  logic       reset;
  logic       sck;
  logic       cs;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       miso;
  logic       miso_oe;
  logic       tx_done;
  logic       underrun;
  logic       frame_abort;

  int n_vec;
  int n_err;

  int n_done;
  int n_under;
  int n_abort;
  int n_long;
  logic p_done;
  logic p_under;
  logic p_abort;

  spi_slave_tx #(.DEFAULT_BYTE(8'h00)) dut (
    .clk        (clk),
    .reset      (reset),
    .sck        (sck),
    .cs         (cs),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .tx_done    (tx_done),
    .underrun   (underrun),
    .frame_abort(frame_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    n_done  = 0;
    n_under = 0;
    n_abort = 0;
    n_long  = 0;
    p_done  = 1'b0;
    p_under = 1'b0;
    p_abort = 1'b0;
  end

  always @(negedge clk) begin
    if (tx_done) n_done = n_done + 1;
    if (underrun) n_under = n_under + 1;
    if (frame_abort) n_abort = n_abort + 1;
    if ((tx_done && p_done) || (underrun && p_under) ||
        (frame_abort && p_abort)) n_long = n_long + 1;
    p_done  = tx_done;
    p_under = underrun;
    p_abort = frame_abort;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic cs_low();
    cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    cs = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Mode-1 master: sck high 2 clk, low 2 clk, sample miso at the fall.
  task automatic xfer(input int nbits, input logic mid_ld,
                      input logic [7:0] mid_d, output logic [7:0] rx,
                      output logic rdy3);
    rx   = 8'h00;
    rdy3 = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      sck = 1'b1;
      if (mid_ld && i == 3) begin
        tx_data  = mid_d;
        tx_valid = 1'b1;
      end
      @(negedge clk);
      tx_valid = 1'b0;
      @(negedge clk);
      rx  = {rx[6:0], miso};
      sck = 1'b0;
      @(negedge clk);
      if (i == 0) rdy3 = tx_ready;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic       ld;
    logic [7:0] data;
    logic [7:0] exp_rx;
    int         exp_done;
    int         exp_under;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [7:0] rx;
    logic [7:0] rx2;
    logic       rdy;
    int b_done;
    int b_under;
    int b_abort;

    n_vec = 0;
    n_err = 0;

    tbl[0] = '{1'b1, 8'hA5, 8'hA5, 1, 0};
    tbl[1] = '{1'b0, 8'h00, 8'h00, 1, 1};
    tbl[2] = '{1'b1, 8'hFF, 8'hFF, 1, 0};
    tbl[3] = '{1'b1, 8'h80, 8'h80, 1, 0};
    tbl[4] = '{1'b1, 8'h01, 8'h01, 1, 0};
    tbl[5] = '{1'b0, 8'h00, 8'h00, 1, 1};

    reset    = 1'b1;
    sck      = 1'b0;
    cs       = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", tx_ready, 1);
    chk("rst_oe", miso_oe, 0);
    chk("rst_miso", miso, 0);
    chk("rst_pulses", {tx_done, underrun, frame_abort}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single-byte frames
    for (int v = 0; v < 6; v++) begin
      b_done  = n_done;
      b_under = n_under;
      b_abort = n_abort;
      if (tbl[v].ld) begin
        load(tbl[v].data);
        chk($sformatf("v%0d_full", v), tx_ready, 0);
      end
      cs_low();
      chk($sformatf("v%0d_oe", v), miso_oe, 1);
      xfer(8, 1'b0, 8'h00, rx, rdy);
      cs_high();
      chk($sformatf("v%0d_rx", v), rx, tbl[v].exp_rx);
      chk($sformatf("v%0d_rdy3", v), rdy, 1);
      chk($sformatf("v%0d_done", v), n_done - b_done, tbl[v].exp_done);
      chk($sformatf("v%0d_under", v), n_under - b_under,
          tbl[v].exp_under);
      chk($sformatf("v%0d_abort", v), n_abort - b_abort, 0);
      chk($sformatf("v%0d_oe_off", v), {miso_oe, miso}, 0);
    end

    // Back-to-back bytes, second loaded mid-way through the first
    b_done  = n_done;
    b_under = n_under;
    load(8'h55);
    cs_low();
    xfer(8, 1'b1, 8'h24, rx, rdy);
    chk("b2b_full_mid", tx_ready, 0);
    xfer(8, 1'b0, 8'h00, rx2, rdy);
    cs_high();
    chk("b2b_rx0", rx, 8'h55);
    chk("b2b_rx1", rx2, 8'h24);
    chk("b2b_done", n_done - b_done, 2);
    chk("b2b_under", n_under - b_under, 0);

    // cs rises after three bits
    b_done  = n_done;
    b_abort = n_abort;
    load(8'hF0);
    cs_low();
    xfer(3, 1'b0, 8'h00, rx, rdy);
    chk("abt_part", rx, 8'h07);
    cs_high();
    chk("abt_abort", n_abort - b_abort, 1);
    chk("abt_done", n_done - b_done, 0);
    chk("abt_oe", miso_oe, 0);
    chk("abt_miso", miso, 0);
    chk("abt_ready", tx_ready, 1);
    load(8'h0F);
    cs_low();
    xfer(8, 1'b0, 8'h00, rx, rdy);
    cs_high();
    chk("abt_next_rx", rx, 8'h0F);
    chk("abt_next_abort", n_abort - b_abort, 1);
    chk("abt_next_done", n_done - b_done, 1);

    // Write while full is ignored
    load(8'h11);
    load(8'h22);
    chk("ovr_ready", tx_ready, 0);
    cs_low();
    xfer(8, 1'b0, 8'h00, rx, rdy);
    cs_high();
    chk("ovr_rx", rx, 8'h11);
    chk("ovr_empty", tx_ready, 1);

    // Reset in the middle of a byte with a second byte buffered
    b_done  = n_done;
    b_under = n_under;
    load(8'h77);
    cs_low();
    xfer(4, 1'b0, 8'h00, rx, rdy);
    load(8'h99);
    chk("rmid_full", tx_ready, 0);
    sck = 1'b1;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rmid_ready", tx_ready, 1);
    chk("rmid_oe", miso_oe, 0);
    chk("rmid_miso", miso, 0);
    chk("rmid_pulses", {tx_done, underrun, frame_abort}, 0);
    sck = 1'b0;
    cs  = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rmid_ready2", tx_ready, 1);
    b_done  = n_done;
    b_under = n_under;
    load(8'h3C);
    cs_low();
    xfer(8, 1'b0, 8'h00, rx, rdy);
    cs_high();
    chk("rmid_rx", rx, 8'h3C);
    chk("rmid_done", n_done - b_done, 1);
    chk("rmid_under", n_under - b_under, 0);

    chk("pulse_width", n_long, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
